// File: rtl/boot_seq_pkg.sv
// rtl/boot_seq_pkg.sv - shared state encodings and timing constants for the boot LED sequencer
package boot_seq_pkg;

  typedef enum logic [1:0] {
    ST_ALL_ON  = 2'd0,
    ST_ALL_OFF = 2'd1,
    ST_SWEEP   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int STEP_1S_40MHZ = 40000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - terminal-count phase timer with two selectable terminal values
module phase_timer #(
  parameter int CNT_W  = 2,
  parameter int TERM_A = 3,
  parameter int TERM_B = 1
) (
  input  logic i_clk,
  input  logic i_res_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_sel_b,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] C_TERM_A = CNT_W'(TERM_A);
  localparam logic [CNT_W-1:0] C_TERM_B = CNT_W'(TERM_B);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_term;

  assign w_term = i_sel_b ? C_TERM_B : C_TERM_A;
  assign o_tick = i_en && (r_cnt == w_term);

  // Terminal compare restarts from zero; the counter never runs past terminal.
  always_ff @(posedge i_clk) begin
    if (!i_res_n || i_clr) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/boot_led_seq.sv
// rtl/boot_led_seq.sv - power-up LED sequencer: all on, all off, optional sweep, then pass-through
module boot_led_seq
  import boot_seq_pkg::*;
#(
  parameter int NUM_LED      = 4,
  parameter int STEP_CYCLES  = STEP_1S_40MHZ,
  parameter int SWEEP_EN     = 1,
  parameter int SWEEP_CYCLES = 4000000
) (
  input  logic               i_clk,
  input  logic               i_res_n,
  input  logic               i_restart,
  input  logic               i_skip,
  input  logic [NUM_LED-1:0] i_led,
  output logic [NUM_LED-1:0] o_led,
  output logic               o_boot_done
);

  localparam int CNT_W = $clog2(max_int(STEP_CYCLES, SWEEP_CYCLES));
  localparam int POS_W = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LED - 1);

  state_t             r_st;
  state_t             w_st_nxt;
  logic [POS_W-1:0]   r_pos;
  logic [POS_W-1:0]   w_pos_nxt;
  logic               w_tick;
  logic [NUM_LED-1:0] w_onehot;

  phase_timer #(
    .CNT_W  (CNT_W),
    .TERM_A (STEP_CYCLES - 1),
    .TERM_B (SWEEP_CYCLES - 1)
  ) u_timer (
    .i_clk   (i_clk),
    .i_res_n (i_res_n),
    .i_clr   (i_restart | i_skip),
    .i_en    (r_st != ST_DONE),
    .i_sel_b (r_st == ST_SWEEP),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      r_st  <= ST_ALL_ON;
      r_pos <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_pos <= w_pos_nxt;
    end
  end

  always_comb begin
    w_st_nxt  = r_st;
    w_pos_nxt = r_pos;
    if (i_restart) begin
      w_st_nxt  = ST_ALL_ON;
      w_pos_nxt = '0;
    end else if (i_skip) begin
      w_st_nxt = ST_DONE;
    end else begin
      case (r_st)
        ST_ALL_ON: if (w_tick) w_st_nxt = ST_ALL_OFF;
        ST_ALL_OFF: begin
          if (w_tick) begin
            w_pos_nxt = '0;
            w_st_nxt  = (SWEEP_EN != 0) ? ST_SWEEP : ST_DONE;
          end
        end
        ST_SWEEP: begin
          if (w_tick) begin
            if (r_pos == LAST_POS) w_st_nxt = ST_DONE;
            else                   w_pos_nxt = r_pos + 1'b1;
          end
        end
        default: w_st_nxt = ST_DONE;
      endcase
    end
  end

  assign w_onehot = NUM_LED'(1) << r_pos;

  // DONE passes the functional LEDs straight through with no register stage.
  always_comb begin
    o_led       = '1;
    o_boot_done = 1'b0;
    case (r_st)
      ST_ALL_ON:  o_led = '1;
      ST_ALL_OFF: o_led = '0;
      ST_SWEEP:   o_led = w_onehot;
      default: begin
        o_led       = i_led;
        o_boot_done = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_boot_led_seq.sv
// tb/tb_boot_led_seq.sv - table-driven scoreboard bench for three boot_led_seq configurations
module tb_boot_led_seq;
  import boot_seq_pkg::*;

  logic       clk = 1'b0;
  logic       res_n, restart, skip;
  logic [3:0] iled;
  logic [3:0] led_a, led_b;
  logic [0:0] led_c;
  logic       done_a, done_b, done_c;

  always #5 clk = ~clk;

  boot_led_seq #(.NUM_LED(4), .STEP_CYCLES(4), .SWEEP_EN(1), .SWEEP_CYCLES(2)) u_a (
    .i_clk(clk), .i_res_n(res_n), .i_restart(restart), .i_skip(skip),
    .i_led(iled), .o_led(led_a), .o_boot_done(done_a));

  boot_led_seq #(.NUM_LED(4), .STEP_CYCLES(4), .SWEEP_EN(0), .SWEEP_CYCLES(2)) u_b (
    .i_clk(clk), .i_res_n(res_n), .i_restart(restart), .i_skip(skip),
    .i_led(iled), .o_led(led_b), .o_boot_done(done_b));

  boot_led_seq #(.NUM_LED(1), .STEP_CYCLES(4), .SWEEP_EN(1), .SWEEP_CYCLES(3)) u_c (
    .i_clk(clk), .i_res_n(res_n), .i_restart(restart), .i_skip(skip),
    .i_led(iled[0:0]), .o_led(led_c), .o_boot_done(done_c));

  int checks = 0;
  int errors = 0;

  int p_n[3]  = '{4, 4, 1};
  int p_st[3] = '{4, 4, 4};
  int p_sw[3] = '{2, 2, 3};
  int p_en[3] = '{1, 0, 1};

  typedef struct packed {
    logic        res_n;
    logic        restart;
    logic        skip;
    logic [3:0]  iled;
    logic [11:0] exp_led;
    logic [2:0]  exp_done;
  } vec_t;

  typedef struct packed {
    int          cyc;
    logic [11:0] led;
    logic [2:0]  done;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic check(input string name, input int cyc, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs from the phase-length formula, relative to the last (re)start.
  function automatic void model(input int d, input int rel, input bit skipped, input logic [3:0] il,
                                output logic [3:0] led, output logic done);
    logic [3:0] mask;
    int st, sw, n;
    n    = p_n[d];
    st   = p_st[d];
    sw   = p_sw[d];
    mask = 4'((1 << n) - 1);
    done = 1'b0;
    if (skipped || rel >= 2 * st + p_en[d] * n * sw) begin
      led  = il & mask;
      done = 1'b1;
    end else if (rel < st) begin
      led = mask;
    end else if (rel < 2 * st) begin
      led = 4'h0;
    end else begin
      led = 4'(1 << ((rel - 2 * st) / sw));
    end
  endfunction

  task automatic add(input int cnt, input logic rn, input logic rs, input logic sk, input logic [3:0] il);
    vec_t v;
    v = '0;
    v.res_n = rn; v.restart = rs; v.skip = sk; v.iled = il;
    for (int i = 0; i < cnt; i++) tbl.push_back(v);
  endtask

  task automatic fill_expected;
    int start[3];
    bit skd[3];
    vec_t v;
    logic [3:0] l;
    logic dn;
    for (int d = 0; d < 3; d++) begin start[d] = 0; skd[d] = 1'b0; end
    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      for (int d = 0; d < 3; d++) begin
        model(d, k - start[d], skd[d], v.iled, l, dn);
        v.exp_led[d*4 +: 4] = l;
        v.exp_done[d] = dn;
        if (!v.res_n || v.restart) begin
          start[d] = k + 1;
          skd[d]   = 1'b0;
        end else if (v.skip) begin
          skd[d] = 1'b1;
        end
      end
      tbl[k] = v;
    end
  endtask

  task automatic do_reset;
    res_n = 1'b0; restart = 1'b0; skip = 1'b0; iled = 4'b1010;
    repeat (2) @(posedge clk);
    #1;
    check("rst_led_a", -1, led_a, 4'hF);
    check("rst_done_a", -1, {3'b0, done_a}, 4'h0);
    check("rst_led_b", -1, led_b, 4'hF);
    check("rst_led_c", -1, {3'b0, led_c}, 4'h1);
    check("rst_done_c", -1, {3'b0, done_c}, 4'h0);
  endtask

  task automatic run_table(input string tag);
    vec_t v;
    exp_t e;
    fill_expected();
    do_reset();
    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      res_n = v.res_n; restart = v.restart; skip = v.skip; iled = v.iled;
      sb.push_back('{k, v.exp_led, v.exp_done});
      @(negedge clk);
      e = sb.pop_front();
      check({tag, "_led_a"},  e.cyc, led_a, e.led[3:0]);
      check({tag, "_done_a"}, e.cyc, {3'b0, done_a}, {3'b0, e.done[0]});
      check({tag, "_led_b"},  e.cyc, led_b, e.led[7:4]);
      check({tag, "_done_b"}, e.cyc, {3'b0, done_b}, {3'b0, e.done[1]});
      check({tag, "_led_c"},  e.cyc, {3'b0, led_c}, e.led[11:8]);
      check({tag, "_done_c"}, e.cyc, {3'b0, done_c}, {3'b0, e.done[2]});
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  initial begin
    res_n = 1'b0; restart = 1'b0; skip = 1'b0; iled = 4'b1010;

    // Full boot, restart from DONE at cycle 20, then i_led toggles in DONE.
    add(20, 1'b1, 1'b0, 1'b0, 4'b1010);
    add(1,  1'b1, 1'b1, 1'b0, 4'b1010);
    add(19, 1'b1, 1'b0, 1'b0, 4'b1010);
    for (int i = 0; i < 8; i++) add(1, 1'b1, 1'b0, 1'b0, 4'(i * 3 + 1));
    run_table("boot");

    // Skip at cycle 5, then restart together with skip at cycle 9.
    add(5,  1'b1, 1'b0, 1'b0, 4'b1010);
    add(1,  1'b1, 1'b0, 1'b1, 4'b1010);
    add(3,  1'b1, 1'b0, 1'b0, 4'b1010);
    add(1,  1'b1, 1'b1, 1'b1, 4'b1010);
    add(22, 1'b1, 1'b0, 1'b0, 4'b0110);
    run_table("skip");

    // One-edge reset mid-sweep at cycle 11.
    add(11, 1'b1, 1'b0, 1'b0, 4'b1010);
    add(1,  1'b0, 1'b0, 1'b0, 4'b1010);
    add(24, 1'b1, 1'b0, 1'b0, 4'b1010);
    run_table("mreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_led_seq.md
Name: boot_led_seq

Overview:
Parametrised power-up LED sequencer for the SFP transceiver board. It drives NUM_LED indicator LEDs through a boot pattern, then hands the LEDs over to the functional status signals and asserts a done flag.
- Boot pattern: all on, all off, then an optional one-hot walking sweep.
- Adds to the previous generation: configurable LED count, configurable phase durations, the sweep phase, and runtime restart and skip controls.
- Sits between the link-status logic and the LED output pins; o_boot_done gates downstream enable logic.

Parameters:
NUM_LED, 4, number of LEDs driven; legal range 1..16.
STEP_CYCLES, 40000000, clock cycles spent in each of ALL_ON and ALL_OFF (1 s at 40 MHz); must be >= 2.
SWEEP_EN, 1, 1 = include the SWEEP phase; 0 = go from ALL_OFF directly to DONE.
SWEEP_CYCLES, 4000000, clock cycles each one-hot position is held during SWEEP; must be >= 2.

Ports:
i_clk  input  1  system clock.
i_res_n  input  1  reset: synchronous, active-low.
i_restart  input  1  single-cycle pulse; restarts the boot sequence from ALL_ON.
i_skip  input  1  single-cycle pulse; jumps straight to DONE.
i_led  input  NUM_LED  functional LED values, passed through in DONE.
o_led  output  NUM_LED  LED drive, 1 = LED on.
o_boot_done  output  1  high only in DONE.

Behaviour:
- State registers:
  - st: ALL_ON, ALL_OFF, SWEEP, DONE.
  - cnt: width $clog2(max(STEP_CYCLES, SWEEP_CYCLES)).
  - pos: sweep index, width $clog2(NUM_LED) with a minimum of 1.
- Synchronous reset: any clock edge with i_res_n=0 sets st=ALL_ON, cnt=0, pos=0. This applies mid-sequence and in DONE alike.
- Reset values of outputs: o_led = all ones, o_boot_done = 0.
- Priority per clock edge: reset > i_restart > i_skip > normal counting.
  - i_restart: st=ALL_ON, cnt=0, pos=0. Accepted in any state, DONE included.
  - i_skip: st=DONE, cnt=0. In DONE it has no effect. If asserted together with i_restart, restart wins.
- Phase ALL_ON: o_led = all ones. When cnt == STEP_CYCLES-1: cnt=0, st=ALL_OFF. Otherwise cnt++.
- Phase ALL_OFF: o_led = all zeros. When cnt == STEP_CYCLES-1: cnt=0, pos=0, st = SWEEP if SWEEP_EN else DONE.
- Phase SWEEP: o_led = one-hot with bit pos set, starting at bit 0.
  - When cnt == SWEEP_CYCLES-1: cnt=0.
  - Then, if pos == NUM_LED-1: st=DONE; otherwise pos++.
  - With NUM_LED=1 this gives a single SWEEP step.
- Phase DONE: o_led = i_led, combinational with zero latency. o_boot_done=1. The counter is held at 0, so DONE consumes no dynamic toggling.
- Output timing: o_led and o_boot_done are combinational decodes of st/pos, i.e. they change in the same cycle as the state register.
- Counter never wraps: terminal compare only, with no free-run past terminal.
- Phase lengths after reset release, counting the first edge with i_res_n=1 as cycle 0:
  - ALL_ON occupies cycles 0..STEP_CYCLES-1.
  - ALL_OFF: STEP_CYCLES cycles.
  - SWEEP: NUM_LED*SWEEP_CYCLES cycles.
  - DONE is entered at cycle 2*STEP_CYCLES + SWEEP_EN*NUM_LED*SWEEP_CYCLES.
- No X propagation: pos is forced to 0 on every entry to SWEEP.

Decomposition:
- Shared header/package boot_seq_pkg:
  - state encodings: ST_ALL_ON=2'd0, ST_ALL_OFF=2'd1, ST_SWEEP=2'd2, ST_DONE=2'd3;
  - default timing constant STEP_1S_40MHZ=40000000.
- One natural sub-module, phase_timer: terminal-count counter with clear and enable inputs, parameter TERM, and a one-cycle o_tick output at terminal. It is instanced once, with TERM muxed per phase through two compare constants. A single shared counter is fine if simpler.

Test Plan (NUM_LED=4, STEP_CYCLES=4, SWEEP_CYCLES=2, SWEEP_EN=1, i_led=4'b1010 unless stated):
1. Release reset, idle inputs -> o_led=1111 for cycles 0-3, 0000 for 4-7, 0001 for 8-9, 0010 for 10-11, 0100 for 12-13, 1000 for 14-15; from cycle 16, o_led=1010 and o_boot_done=1.
2. SWEEP_EN=0 -> o_led=1111 for cycles 0-3, 0000 for 4-7; DONE at cycle 8 with o_led=i_led.
3. Pulse i_restart at cycle 20 (in DONE) -> cycle 21 o_led=1111, o_boot_done=0; full sequence repeats and DONE is re-entered at cycle 37.
4. Pulse i_skip at cycle 5 -> cycle 6 o_boot_done=1, o_led=1010. Pulse i_restart and i_skip together at cycle 9 -> restart wins, cycle 10 o_led=1111.
5. Assert i_res_n=0 for one edge at cycle 11 (mid-SWEEP) -> o_led=1111 and o_boot_done=0 from the next cycle; after release the sequence restarts from ALL_ON with full phase lengths.
6. NUM_LED=1, SWEEP_CYCLES=3 -> o_led=1 for cycles 0-3, 0 for cycles 4-7, 1 for cycles 8-10, DONE at cycle 11. Toggle i_led in DONE -> o_led follows in the same cycle.
